// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN-VAD binary datapath: bit encoding and
// packing-geometry helpers.
package bnn_pkg;

   localparam logic BIN_POS = 1'b1;  // +1
   localparam logic BIN_NEG = 1'b0;  // -1

   function automatic int beats(input int pack_w, input int ch);
      return pack_w / ch;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bin_pack_stream_if.sv
// Input beat stream and packed output word stream of the binarizer.
interface bin_pack_stream_if #(
   parameter int DATA_W = 32,
   parameter int CH     = 4,
   parameter int PACK_W = 32
);
   localparam int NB_W = $clog2(PACK_W) + 1;

   logic                   in_valid;
   logic                   in_ready;
   logic [CH*DATA_W-1:0]   in_data;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [PACK_W-1:0]      out_data;
   logic [NB_W-1:0]        out_nbits;
   logic                   out_last;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_nbits, out_last
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_nbits, out_last
   );

endinterface

// File: rtl/bin_lane_cmp.sv
// One lane of the binarizer: threshold compare with polarity flip, or a
// plain sign test when sign-only mode is selected.
module bin_lane_cmp
   import bnn_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic signed [DATA_W-1:0] i_x,
   input  logic signed [DATA_W-1:0] i_thr,
   input  logic                     i_flip,
   input  logic                     i_sign_only,
   output logic                     o_bit
);

   logic w_ge_zero;
   logic w_ge_thr;

   assign w_ge_zero = ~i_x[DATA_W-1];
   assign w_ge_thr  = (i_x >= i_thr);

   // Folded batch-norm: a negative scale turns the threshold test around.
   assign o_bit = i_sign_only ? (w_ge_zero ? BIN_POS : BIN_NEG)
                              : ((w_ge_thr ^ i_flip) ? BIN_POS : BIN_NEG);

endmodule

// File: rtl/bin_pack_stream.sv
// Streaming binarizer: thresholds CH lanes per beat and packs the bits into
// PACK_W-bit words, flushing early on frame end.
module bin_pack_stream
   import bnn_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CH     = 4,
   parameter int PACK_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_sign_only,
   input  logic                     thr_we,
   input  logic [$clog2(CH)-1:0]    thr_addr,
   input  logic signed [DATA_W-1:0] thr_data,
   input  logic                     thr_flip,
   bin_pack_stream_if.slave         bus
);

   localparam int BEATS = beats(PACK_W, CH);
   localparam int CW    = cnt_w(BEATS);
   localparam int NB_W  = $clog2(PACK_W) + 1;
   localparam int AW    = $clog2(CH);
   localparam logic [AW:0] CH_L = (AW + 1)'(CH);

   logic signed [DATA_W-1:0] r_thr [CH];
   logic [CH-1:0]            r_flip;

   logic [PACK_W-1:0] r_acc,       w_acc_n;
   logic [CW-1:0]     r_cnt,       w_cnt_n;
   logic [PACK_W-1:0] r_out_data,  w_out_data_n;
   logic [NB_W-1:0]   r_out_nbits, w_out_nbits_n;
   logic              r_out_last,  w_out_last_n;
   logic              r_out_valid, w_out_valid_n;

   logic [CH-1:0]     w_bits;
   logic              w_accept;
   logic              w_final;
   logic [PACK_W-1:0] w_word;

   for (genvar g = 0; g < CH; g++) begin : g_lane
      bin_lane_cmp #(.DATA_W(DATA_W)) u_cmp (
         .i_x         (bus.in_data[g*DATA_W +: DATA_W]),
         .i_thr       (r_thr[g]),
         .i_flip      (r_flip[g]),
         .i_sign_only (cfg_sign_only),
         .o_bit       (w_bits[g])
      );
   end

   // NOTE: the threshold file is a handful of flops, so it is reset in place;
   // a RAM-backed array would instead need an explicit clear sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) r_thr[i] <= '0;
         r_flip <= '0;
      end else if (thr_we && ({1'b0, thr_addr} < CH_L)) begin
         r_thr[thr_addr]  <= thr_data;
         r_flip[thr_addr] <= thr_flip;
      end
   end

   assign bus.in_ready = !r_out_valid || bus.out_ready;
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_final      = (r_cnt == CW'(BEATS - 1)) || bus.in_last;
   assign w_word       = r_acc | (PACK_W'(w_bits) << (int'(r_cnt) * CH));

   // NOTE: every next-state value gets its hold default first, so no path
   // through this block leaves a variable unassigned and no latch appears.
   always_comb begin
      w_acc_n       = r_acc;
      w_cnt_n       = r_cnt;
      w_out_data_n  = r_out_data;
      w_out_nbits_n = r_out_nbits;
      w_out_last_n  = r_out_last;
      w_out_valid_n = r_out_valid;

      if (r_out_valid && bus.out_ready) w_out_valid_n = 1'b0;

      // A final beat may land in the same cycle the old word retires.
      if (w_accept) begin
         if (w_final) begin
            w_out_data_n  = w_word;
            w_out_nbits_n = NB_W'((int'(r_cnt) + 1) * CH);
            w_out_last_n  = bus.in_last;
            w_out_valid_n = 1'b1;
            w_acc_n       = '0;
            w_cnt_n       = '0;
         end else begin
            w_acc_n = w_word;
            w_cnt_n = r_cnt + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_data  <= '0;
         r_out_nbits <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_acc       <= w_acc_n;
         r_cnt       <= w_cnt_n;
         r_out_data  <= w_out_data_n;
         r_out_nbits <= w_out_nbits_n;
         r_out_last  <= w_out_last_n;
         r_out_valid <= w_out_valid_n;
      end
   end

   assign bus.out_data  = r_out_data;
   assign bus.out_nbits = r_out_nbits;
   assign bus.out_last  = r_out_last;
   assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_bin_pack_stream.sv
// Scoreboard bench for bin_pack_stream: directed scenarios plus random beats
// checked against a bit-list reference model.
module tb_bin_pack_stream;

   localparam int DATA_W = 32;
   localparam int CH     = 4;
   localparam int PACK_W = 32;
   localparam int NB_W   = 6;

   typedef struct packed {
      logic [PACK_W-1:0] data;
      logic [NB_W-1:0]   nbits;
      logic              last;
   } word_t;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     cfg_sign_only = 1'b0;
   logic                     thr_we = 1'b0;
   logic [1:0]               thr_addr = '0;
   logic signed [DATA_W-1:0] thr_data = '0;
   logic                     thr_flip = 1'b0;

   bin_pack_stream_if #(.DATA_W(DATA_W), .CH(CH), .PACK_W(PACK_W)) bus ();

   bin_pack_stream #(.DATA_W(DATA_W), .CH(CH), .PACK_W(PACK_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_sign_only (cfg_sign_only),
      .thr_we        (thr_we),
      .thr_addr      (thr_addr),
      .thr_data      (thr_data),
      .thr_flip      (thr_flip),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int ready_mode = 1;   // 0 random, 1 always ready, 2 stalled
   int accept_cyc = 0;
   int hs_cyc     = 0;
   word_t last_word = '0;

   word_t sb[$];
   logic signed [DATA_W-1:0] m_thr [CH];
   logic                     m_flip [CH];
   logic [PACK_W-1:0]        m_cur = '0;
   int                       m_nb  = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [CH*DATA_W-1:0] pk(input int a, input int b, input int c, input int d);
      return {d, c, b, a};
   endfunction

   function automatic void model_clear();
      sb.delete();
      m_cur = '0;
      m_nb  = 0;
      for (int i = 0; i < CH; i++) begin
         m_thr[i]  = '0;
         m_flip[i] = 1'b0;
      end
   endfunction

   // Appends the beat's bits to the frame bit list; a full word or frame end emits.
   function automatic void model_beat(input logic [CH*DATA_W-1:0] d, input logic last, input logic so);
      logic signed [DATA_W-1:0] x;
      logic b;
      word_t w;
      for (int i = 0; i < CH; i++) begin
         x = d[i*DATA_W +: DATA_W];
         b = so ? (x >= 0) : ((x >= m_thr[i]) != m_flip[i]);
         m_cur[m_nb + i] = b;
      end
      m_nb += CH;
      if (m_nb == PACK_W || last) begin
         w.data  = m_cur;
         w.nbits = NB_W'(m_nb);
         w.last  = last;
         sb.push_back(w);
         m_cur = '0;
         m_nb  = 0;
      end
   endfunction

   function automatic void model_write(input logic [1:0] a, input logic signed [DATA_W-1:0] t, input logic f);
      m_thr[a]  = t;
      m_flip[a] = f;
   endfunction

   task automatic send_beat(input logic [CH*DATA_W-1:0] d, input logic last, input logic so,
                            input logic we, input logic [1:0] a,
                            input logic signed [DATA_W-1:0] t, input logic f);
      bit done = 0;
      bit acc;
      int waits = 0;
      while (!done) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.in_data   = d;
         bus.in_last   = last;
         cfg_sign_only = so;
         thr_we        = we;
         thr_addr      = a;
         thr_data      = t;
         thr_flip      = f;
         #1;
         acc = bus.in_ready;
         if (acc) accept_cyc = cyc + 1;
         @(posedge clk);
         if (acc) begin
            model_beat(d, last, so);
            done = 1;
         end
         if (we) model_write(a, t, f);
         waits++;
         if (!done && waits > 200) begin
            check("beat_accept_timeout", 64'd0, 64'd1);
            break;
         end
      end
      #1;
      bus.in_valid = 1'b0;
      thr_we       = 1'b0;
   endtask

   task automatic write_thr(input logic [1:0] a, input logic signed [DATA_W-1:0] t, input logic f);
      @(negedge clk);
      thr_we   = 1'b1;
      thr_addr = a;
      thr_data = t;
      thr_flip = f;
      @(posedge clk);
      model_write(a, t, f);
      #1;
      thr_we = 1'b0;
   endtask

   task automatic send_word(input logic [CH*DATA_W-1:0] d, input int n, input logic last_on_end, input logic so);
      for (int k = 0; k < n; k++)
         send_beat(d, last_on_end && (k == n - 1), so, 1'b0, 2'd0, '0, 1'b0);
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((sb.size() != 0 || bus.out_valid) && k < 500) begin
         @(negedge clk);
         #2;
         k++;
      end
      check("drain", 64'(k < 500), 64'd1);
   endtask

   // Monitor: drives out_ready and compares every handshaked word with the scoreboard.
   initial begin
      word_t got, exp;
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) bus.out_ready = 1'b0;
         else case (ready_mode)
            0:       bus.out_ready = ($urandom_range(0, 3) != 0);
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'b0;
         endcase
         #1;
         if (!rst && bus.out_valid && bus.out_ready) begin
            hs_cyc    = cyc + 1;
            got.data  = bus.out_data;
            got.nbits = bus.out_nbits;
            got.last  = bus.out_last;
            last_word = got;
            if (sb.size() == 0) check("unexpected_word", 64'(got), 64'd0 - 1);
            else begin
               exp = sb.pop_front();
               check("word", 64'(got), 64'(exp));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [PACK_W-1:0] held;
      logic [CH*DATA_W-1:0] d;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      model_clear();

      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data",  64'(bus.out_data),  64'd0);
      check("rst_out_nbits", 64'(bus.out_nbits), 64'd0);
      check("rst_out_last",  64'(bus.out_last),  64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Sign-only full word.
      ready_mode = 1;
      send_word(pk(5, -1, 0, -7), 8, 1'b0, 1'b1);
      wait_drain();
      check("sign_only_word", 64'(last_word), 64'({32'h55555555, 6'd32, 1'b0}));

      // Per-lane thresholds with a flipped lane.
      for (int i = 0; i < CH; i++) write_thr(2'(i), 10, (i == 3));
      send_word(pk(10, 9, 11, 9), 8, 1'b0, 1'b0);
      wait_drain();
      check("thr_flip_word", 64'(last_word), 64'({32'hDDDDDDDD, 6'd32, 1'b0}));

      // Frame end after three beats, then a full word from a clean start.
      send_word(pk(1, 1, 1, 1), 3, 1'b1, 1'b1);
      wait_drain();
      check("partial_word", 64'(last_word), 64'({32'h00000FFF, 6'd12, 1'b1}));
      send_word(pk(1, -1, 1, -1), 8, 1'b0, 1'b1);
      wait_drain();
      check("after_partial", 64'(last_word), 64'({32'h55555555, 6'd32, 1'b0}));

      // Backpressure: word held for five cycles, next beat taken on release.
      ready_mode = 2;
      send_word(pk(-1, 2, -3, 4), 8, 1'b0, 1'b1);
      held = bus.out_data;
      fork
         send_beat(pk(7, 7, 7, 7), 1'b0, 1'b1, 1'b0, 2'd0, '0, 1'b0);
         begin
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               #2;
               check("stall_in_ready", 64'(bus.in_ready), 64'd0);
               check("stall_data",     64'(bus.out_data), 64'(held));
            end
            ready_mode = 1;
         end
      join
      check("release_same_cycle", 64'(accept_cyc), 64'(hs_cyc));
      check("stalled_word", 64'(held), 64'h00000000AAAAAAAA);
      send_word(pk(7, 7, 7, 7), 7, 1'b0, 1'b1);
      wait_drain();

      // Threshold write coinciding with a beat.
      write_thr(2'd0, 0, 1'b0);
      send_beat(pk(50, 0, 0, 0), 1'b0, 1'b0, 1'b1, 2'd0, 100, 1'b0);
      send_word(pk(50, 0, 0, 0), 7, 1'b0, 1'b0);
      wait_drain();
      check("thr_same_cycle", 64'({last_word.data[4], last_word.data[0]}), 64'd1);

      // Asynchronous reset mid-word.
      send_word(pk(-9, -9, -9, -9), 4, 1'b0, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_out_data",  64'(bus.out_data),  64'd0);
      check("midrst_out_nbits", 64'(bus.out_nbits), 64'd0);
      check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      send_word(pk(-3, 4, -5, 6), 8, 1'b0, 1'b1);
      wait_drain();
      check("post_rst_word", 64'(last_word), 64'({32'hAAAAAAAA, 6'd32, 1'b0}));

      // Random traffic under random backpressure.
      ready_mode = 0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 9))
               0:       d[i*DATA_W +: DATA_W] = 32'h80000000;
               1:       d[i*DATA_W +: DATA_W] = 32'h7FFFFFFF;
               default: d[i*DATA_W +: DATA_W] = 32'($signed($urandom_range(0, 40)) - 20);
            endcase
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send_beat(d, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                   32'($signed($urandom_range(0, 30)) - 15), 1'($urandom_range(0, 1)));
      end
      ready_mode = 1;
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
